dp_rx_crc_profile0_chk: RTL and testbench

//  Sink-side Profile 0 CRC checker. Mirrors the TX CRC extension on the receive path.
//  - Computes CRC-32 over each received frame of 192-bit video beats.
//  - Captures the CRC the source sends in its SDP and compares it with the computed value.
//  - Reports mismatch (scalar_crc_err) and missing SDPs to the Policy Maker.
//  - Sits after RX stream unpacking, beside the SDP parser.

---
 rtl/dp_rx_crc_profile0_chk.sv | 140 ++++++++++++++
 tb/tb_dp_rx_crc_profile0_chk.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_rx_crc_profile0_chk.sv
// rtl/dp_rx_crc_profile0_chk.sv - sink-side Profile 0 CRC-32 checker for 192-bit video beats
// Accumulates a frame CRC, pairs it with the SDP-carried CRC and reports mismatch/missing SDP.
module dp_rx_crc_profile0_chk #(
   parameter logic [31:0] CRC_INIT    = 32'hFFFF_FFFF,
   parameter int          TIMEOUT_CYC = 4096,
   parameter int          ERR_CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 video_valid,
   input  logic [191:0]         video_data,
   input  logic                 frame_start,
   input  logic                 frame_end,
   input  logic                 sdp_valid,
   input  logic [31:0]          sdp_crc,
   output logic [31:0]          crc_out,
   output logic                 crc_done,
   output logic                 scalar_crc_err,
   output logic                 sdp_missing,
   output logic [ERR_CNT_W-1:0] err_count
);
   localparam int          TMR_W = $clog2(TIMEOUT_CYC);
   localparam logic [31:0] POLY  = 32'h04C1_1DB7;

   typedef enum logic [1:0] {IDLE, ACCUM, WAIT_SDP, COMPARE} state_t;

   state_t               state, state_d;
   logic [31:0]          acc, acc_d, acc_beat;
   logic [31:0]          held_crc, held_crc_d, crc_out_d;
   logic                 held, held_d, crc_done_d, err_d, missing_d;
   logic [TMR_W-1:0]     timer, timer_d;
   logic [ERR_CNT_W-1:0] err_count_d;

   // MSB-first, unreflected; the loop unrolls into one parallel XOR network
   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [191:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 191; i >= 0; i--) begin
         r = {r[30:0], 1'b0} ^ (((r[31] ^ d[i]) == 1'b1) ? POLY : 32'h0);
      end
      return r;
   endfunction

   always_comb begin
      state_d     = state;
      acc_d       = acc;
      held_d      = held;
      held_crc_d  = held_crc;
      timer_d     = timer;
      crc_out_d   = crc_out;
      crc_done_d  = 1'b0;
      err_d       = scalar_crc_err;
      missing_d   = 1'b0;
      err_count_d = err_count;
      acc_beat    = crc_step(acc, video_data);
      case (state)
         IDLE: begin
            if (frame_start) begin
               state_d = ACCUM;
               acc_d   = CRC_INIT;
               held_d  = 1'b0;
            end
         end
         ACCUM: begin
            if (frame_start) begin
               acc_d  = CRC_INIT;
               held_d = 1'b0;
            end else begin
               if (video_valid) acc_d = acc_beat;
               if (sdp_valid) begin
                  held_crc_d = sdp_crc;
                  held_d     = 1'b1;
               end
               if (frame_end) begin
                  timer_d = '0;
                  state_d = (held || sdp_valid) ? COMPARE : WAIT_SDP;
               end
            end
         end
         WAIT_SDP: begin
            timer_d = timer + TMR_W'(1);
            // a new frame wins over a late SDP arriving in the same cycle
            if (frame_start) begin
               missing_d = 1'b1;
               state_d   = ACCUM;
               acc_d     = CRC_INIT;
               held_d    = 1'b0;
            end else if (sdp_valid) begin
               held_crc_d = sdp_crc;
               held_d     = 1'b1;
               state_d    = COMPARE;
            end else if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
               missing_d = 1'b1;
               state_d   = IDLE;
            end
         end
         COMPARE: begin
            crc_out_d  = acc;
            crc_done_d = 1'b1;
            err_d      = (acc != held_crc);
            if ((acc != held_crc) && (err_count != {ERR_CNT_W{1'b1}}))
               err_count_d = err_count + ERR_CNT_W'(1);
            if (frame_start) begin
               state_d = ACCUM;
               acc_d   = CRC_INIT;
               held_d  = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         acc            <= '0;
         held           <= 1'b0;
         held_crc       <= '0;
         timer          <= '0;
         crc_out        <= '0;
         crc_done       <= 1'b0;
         scalar_crc_err <= 1'b0;
         sdp_missing    <= 1'b0;
         err_count      <= '0;
      end else begin
         state          <= state_d;
         acc            <= acc_d;
         held           <= held_d;
         held_crc       <= held_crc_d;
         timer          <= timer_d;
         crc_out        <= crc_out_d;
         crc_done       <= crc_done_d;
         scalar_crc_err <= err_d;
         sdp_missing    <= missing_d;
         err_count      <= err_count_d;
      end
   end
endmodule

// File: tb/tb_dp_rx_crc_profile0_chk.sv
// tb/tb_dp_rx_crc_profile0_chk.sv - randomized self-checking bench for dp_rx_crc_profile0_chk
// Reference CRC is a byte-wise table CRC-32 over the concatenated frame bits.
module tb_dp_rx_crc_profile0_chk;
   logic         clk = 1'b0;
   logic         rst, video_valid, frame_start, frame_end, sdp_valid;
   logic [191:0] video_data;
   logic [31:0]  sdp_crc;
   logic [31:0]  crc_out0, crc_out1;
   logic         crc_done0, crc_done1, err0, err1, miss0, miss1;
   logic [15:0]  err_count0;
   logic [1:0]   err_count1;

   always #5 clk = ~clk;

   dp_rx_crc_profile0_chk #(.TIMEOUT_CYC(16), .ERR_CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .video_valid(video_valid), .video_data(video_data),
      .frame_start(frame_start), .frame_end(frame_end), .sdp_valid(sdp_valid),
      .sdp_crc(sdp_crc), .crc_out(crc_out0), .crc_done(crc_done0),
      .scalar_crc_err(err0), .sdp_missing(miss0), .err_count(err_count0));

   dp_rx_crc_profile0_chk #(.TIMEOUT_CYC(16), .ERR_CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .video_valid(video_valid), .video_data(video_data),
      .frame_start(frame_start), .frame_end(frame_end), .sdp_valid(sdp_valid),
      .sdp_crc(sdp_crc), .crc_out(crc_out1), .crc_done(crc_done1),
      .scalar_crc_err(err1), .sdp_missing(miss1), .err_count(err_count1));

   int           n_pass = 0, n_total = 0, model_err = 0;
   logic [31:0]  tbl [256];
   logic [191:0] beats [8];
   logic [31:0]  exp_crc;
   logic         miss_at_start;
   logic [1:0]   exp_sat;

   function automatic void build_table();
      for (int b = 0; b < 256; b++) begin
         logic [31:0] r;
         r = 32'(b) << 24;
         for (int k = 0; k < 8; k++) r = r[31] ? ((r << 1) ^ 32'h04C1_1DB7) : (r << 1);
         tbl[b] = r;
      end
   endfunction

   function automatic logic [31:0] crc_model(input int n);
      logic [31:0] c;
      logic [7:0]  byt;
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < n; i++)
         for (int k = 23; k >= 0; k--) begin
            byt = beats[i][k*8 +: 8];
            c   = (c << 8) ^ tbl[c[31:24] ^ byt];
         end
      return c;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic gen(input int n);
      for (int i = 0; i < n; i++) beats[i] = {6{$urandom()}};
      exp_crc = crc_model(n);
   endtask

   task automatic clear_in();
      video_valid = 1'b0; frame_start = 1'b0; frame_end = 1'b0; sdp_valid = 1'b0;
   endtask

   // frame_start cycle, then n beats with random idle gaps; frame_end rides the last beat
   task automatic drive_frame(input int n, input int sdp_idx, input logic [31:0] sdp_v);
      frame_start = 1'b1;
      video_data  = {6{$urandom()}};
      tick();
      clear_in();
      miss_at_start = miss0;
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            video_data = {6{$urandom()}};
            tick();
         end
         video_valid = 1'b1;
         video_data  = beats[i];
         sdp_valid   = (i == sdp_idx);
         sdp_crc     = sdp_v;
         frame_end   = (i == n - 1);
         tick();
         clear_in();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; clear_in(); video_data = '0; sdp_crc = '0;
      tick(); tick();
      n_total++; if (crc_out0 !== 32'h0) $display("FAIL reset_crc_out: got %h want 0", crc_out0); else n_pass++;
      n_total++; if ({crc_done0, err0, miss0} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {crc_done0, err0, miss0}); else n_pass++;
      n_total++; if (err_count0 !== 16'h0 || err_count1 !== 2'h0) $display("FAIL reset_err_count: got %0d/%0d want 0/0", err_count0, err_count1); else n_pass++;
      rst = 1'b0;
      model_err = 0;
      for (int i = 0; i < 4; i++) begin
         video_valid = 1'b1; sdp_valid = 1'b1; frame_end = (i == 1);
         video_data = {6{$urandom()}}; sdp_crc = $urandom();
         tick();
         n_total++; if (crc_done0 !== 1'b0 || miss0 !== 1'b0) $display("FAIL idle_ignore: got done=%b miss=%b want 0 0", crc_done0, miss0); else n_pass++;
      end
      clear_in();
   endtask

   task automatic test_good_frame();
      gen(4);
      drive_frame(4, 1, exp_crc);
      n_total++; if (crc_done0 !== 1'b0) $display("FAIL good_early_done: got %b want 0", crc_done0); else n_pass++;
      tick();
      n_total++; if (crc_done0 !== 1'b1) $display("FAIL good_done: got %b want 1", crc_done0); else n_pass++;
      n_total++; if (crc_out0 !== exp_crc) $display("FAIL good_crc: got %h want %h", crc_out0, exp_crc); else n_pass++;
      n_total++; if (err0 !== 1'b0 || err_count0 !== 16'(model_err)) $display("FAIL good_err: got err=%b cnt=%0d want 0 %0d", err0, err_count0, model_err); else n_pass++;
      tick();
      n_total++; if (crc_done0 !== 1'b0) $display("FAIL good_done_pulse: got %b want 0", crc_done0); else n_pass++;
   endtask

   task automatic test_mismatch();
      gen(4);
      drive_frame(4, 2, exp_crc ^ 32'h1);
      model_err++;
      tick();
      n_total++; if (crc_done0 !== 1'b1 || crc_out0 !== exp_crc) $display("FAIL bad_done_crc: got %b %h want 1 %h", crc_done0, crc_out0, exp_crc); else n_pass++;
      n_total++; if (err0 !== 1'b1 || err_count0 !== 16'(model_err)) $display("FAIL bad_err: got err=%b cnt=%0d want 1 %0d", err0, err_count0, model_err); else n_pass++;
      tick(); tick();
      n_total++; if (err0 !== 1'b1) $display("FAIL bad_err_hold: got %b want 1", err0); else n_pass++;
      gen(3);
      drive_frame(3, 0, exp_crc);
      tick();
      n_total++; if (err0 !== 1'b0 || err_count0 !== 16'(model_err)) $display("FAIL recover_err: got err=%b cnt=%0d want 0 %0d", err0, err_count0, model_err); else n_pass++;
      n_total++; if (crc_out0 !== exp_crc) $display("FAIL recover_crc: got %h want %h", crc_out0, exp_crc); else n_pass++;
   endtask

   task automatic test_timeout();
      int first_miss, n_miss, n_done;
      first_miss = -1; n_miss = 0; n_done = 0;
      gen(4);
      drive_frame(4, -1, 32'h0);
      for (int k = 1; k <= 24; k++) begin
         tick();
         if (miss0 === 1'b1) begin
            n_miss++;
            if (first_miss < 0) first_miss = k;
         end
         if (crc_done0 === 1'b1) n_done++;
      end
      n_total++; if (first_miss != 16) $display("FAIL timeout_latency: got %0d want 16", first_miss); else n_pass++;
      n_total++; if (n_miss != 1 || n_done != 0) $display("FAIL timeout_pulses: got miss=%0d done=%0d want 1 0", n_miss, n_done); else n_pass++;
      n_total++; if (err0 !== 1'b0) $display("FAIL timeout_err_kept: got %b want 0", err0); else n_pass++;
      sdp_valid = 1'b1; sdp_crc = exp_crc;
      tick(); clear_in(); tick(); tick();
      n_total++; if (crc_done0 !== 1'b0) $display("FAIL timeout_idle: got done=%b want 0", crc_done0); else n_pass++;
   endtask

   task automatic test_late_sdp();
      gen(5);
      drive_frame(5, -1, 32'h0);
      for (int k = 0; k < 4; k++) begin
         video_valid = 1'b1; video_data = {6{$urandom()}};
         tick();
      end
      clear_in();
      sdp_valid = 1'b1; sdp_crc = exp_crc;
      tick();
      clear_in();
      n_total++; if (crc_done0 !== 1'b0) $display("FAIL late_early_done: got %b want 0", crc_done0); else n_pass++;
      tick();
      n_total++; if (crc_done0 !== 1'b1 || crc_out0 !== exp_crc || err0 !== 1'b0) $display("FAIL late_sdp: got done=%b crc=%h err=%b want 1 %h 0", crc_done0, crc_out0, err0, exp_crc); else n_pass++;
      tick();
      gen(3);
      drive_frame(3, -1, 32'h0);
      tick(); tick(); tick();
      gen(4);
      drive_frame(4, 3, exp_crc);
      n_total++; if (miss_at_start !== 1'b1) $display("FAIL wait_restart_miss: got %b want 1", miss_at_start); else n_pass++;
      tick();
      n_total++; if (crc_done0 !== 1'b1 || crc_out0 !== exp_crc) $display("FAIL wait_restart_crc: got done=%b crc=%h want 1 %h", crc_done0, crc_out0, exp_crc); else n_pass++;
      tick();
   endtask

   task automatic test_edges();
      gen(1);
      drive_frame(1, 0, exp_crc);
      tick();
      n_total++; if (crc_out0 !== exp_crc || err0 !== 1'b0) $display("FAIL end_beat_included: got %h err=%b want %h 0", crc_out0, err0, exp_crc); else n_pass++;
      tick();
      frame_start = 1'b1; tick(); clear_in();
      for (int i = 0; i < 2; i++) begin
         video_valid = 1'b1; video_data = {6{$urandom()}}; sdp_valid = 1'b1; sdp_crc = $urandom();
         tick(); clear_in();
      end
      gen(3);
      drive_frame(3, 1, exp_crc);
      tick();
      n_total++; if (crc_done0 !== 1'b1 || crc_out0 !== exp_crc || err0 !== 1'b0) $display("FAIL restart_crc: got done=%b crc=%h err=%b want 1 %h 0", crc_done0, crc_out0, err0, exp_crc); else n_pass++;
      tick();
      frame_start = 1'b1; tick(); clear_in();
      video_valid = 1'b1; video_data = {6{$urandom()}}; tick();
      rst = 1'b1; tick(); rst = 1'b0; clear_in();
      model_err = 0;
      n_total++; if (crc_out0 !== 32'h0 || {crc_done0, err0, miss0} !== 3'b000 || err_count0 !== 16'h0 || err_count1 !== 2'h0) $display("FAIL midframe_reset: got crc=%h flags=%b cnt=%0d want 0 000 0", crc_out0, {crc_done0, err0, miss0}, err_count0); else n_pass++;
      gen(4);
      drive_frame(4, 2, exp_crc);
      tick();
      n_total++; if (crc_done0 !== 1'b1 || crc_out0 !== exp_crc) $display("FAIL post_reset_crc: got done=%b crc=%h want 1 %h", crc_done0, crc_out0, exp_crc); else n_pass++;
      tick();
   endtask

   task automatic test_saturate();
      for (int f = 0; f < 5; f++) begin
         gen(2);
         drive_frame(2, 0, exp_crc ^ 32'h8000_0000);
         model_err++;
         exp_sat = (model_err > 3) ? 2'd3 : 2'(model_err);
         tick();
         n_total++; if (err_count1 !== exp_sat) $display("FAIL sat_count: got %0d want %0d", err_count1, exp_sat); else n_pass++;
         n_total++; if (err_count0 !== 16'(model_err) || err0 !== 1'b1) $display("FAIL wide_count: got %0d err=%b want %0d 1", err_count0, err0, model_err); else n_pass++;
         tick();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      build_table();
      test_reset();
      test_good_frame();
      test_mismatch();
      test_timeout();
      test_late_sdp();
      test_edges();
      test_saturate();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
